// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract unit resolving SLICE bits per stage, with valid/ready on both sides.
// Define ADDER_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module adder_pipe #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             zero
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int LAST   = STAGES - 1;

  logic             vld_q   [STAGES];
  logic             vld_d   [STAGES];
  logic [WIDTH-1:0] opa_q   [STAGES];
  logic [WIDTH-1:0] opa_d   [STAGES];
  logic [WIDTH-1:0] opb_q   [STAGES];
  logic [WIDTH-1:0] opb_d   [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic             zero_q;
  logic             zero_d;
`ifdef ADDER_PIPE_OVF_EN
  logic             ovf_q;
  logic             ovf_d;
`endif

  // Per-stage inputs (from ports for stage 0, from the previous stage otherwise)
  logic [WIDTH-1:0] src_a     [STAGES];
  logic [WIDTH-1:0] src_b     [STAGES];
  logic [WIDTH-1:0] src_s     [STAGES];
  logic             src_c     [STAGES];
  logic             src_v     [STAGES];
  logic [WIDTH-1:0] res_s     [STAGES];
  logic [SLICE:0]   slice_sum [STAGES];
  logic             adv;

  always_comb begin
    adv = !vld_q[LAST] || out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src_a[k] = a;
        src_b[k] = sub ? ~b : b;
        src_s[k] = '0;
        src_c[k] = sub ? ~cin : cin;
        src_v[k] = in_valid;
      end else begin
        src_a[k] = opa_q[k-1];
        src_b[k] = opb_q[k-1];
        src_s[k] = sum_q[k-1];
        src_c[k] = carry_q[k-1];
        src_v[k] = vld_q[k-1];
      end
      slice_sum[k] = {1'b0, src_a[k][k*SLICE +: SLICE]}
                   + {1'b0, src_b[k][k*SLICE +: SLICE]}
                   + {{SLICE{1'b0}}, src_c[k]};
      res_s[k] = src_s[k];
      res_s[k][k*SLICE +: SLICE] = slice_sum[k][SLICE-1:0];

      vld_d[k]   = adv ? src_v[k]            : vld_q[k];
      opa_d[k]   = adv ? src_a[k]            : opa_q[k];
      opb_d[k]   = adv ? src_b[k]            : opb_q[k];
      sum_d[k]   = adv ? res_s[k]            : sum_q[k];
      carry_d[k] = adv ? slice_sum[k][SLICE] : carry_q[k];
    end
    zero_d = adv ? (res_s[LAST] == '0) : zero_q;
`ifdef ADDER_PIPE_OVF_EN
    // Carry into the MSB is recovered as a ^ b ^ sum at that bit position
    ovf_d = adv ? (src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^
                   res_s[LAST][WIDTH-1] ^ slice_sum[LAST][SLICE])
                : ovf_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k]   <= 1'b0;
        opa_q[k]   <= '0;
        opb_q[k]   <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      zero_q <= 1'b0;
`ifdef ADDER_PIPE_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k]   <= vld_d[k];
        opa_q[k]   <= opa_d[k];
        opb_q[k]   <= opb_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
      end
      zero_q <= zero_d;
`ifdef ADDER_PIPE_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign s         = sum_q[LAST];
  assign c         = carry_q[LAST];
  assign zero      = zero_q;
`ifdef ADDER_PIPE_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: 8-bit/2-stage instance with a scoreboard model, plus a 16-bit/4-stage instance.
module tb_adder_pipe;

  localparam int STAGES = 2;

  logic       clk, reset;
  logic       in_valid, in_ready, sub_i, cin_i, out_valid, out_ready, c_o, zero_o;
  logic [7:0] a_i, b_i, s_o;
  logic        in_valid16, in_ready16, sub16, cin16, out_valid16, out_ready16, c16, zero16;
  logic [15:0] a16, b16, s16;
`ifdef ADDER_PIPE_OVF_EN
  logic ovf_o, ovf16;
`endif

  int errors = 0;
  int checks = 0;
  int out_xfers = 0;

  adder_pipe #(.WIDTH(8), .SLICE(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .sub(sub_i), .cin(cin_i),
    .out_valid(out_valid), .out_ready(out_ready), .s(s_o), .c(c_o), .zero(zero_o)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(ovf_o)
`endif
  );

  adder_pipe #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .sub(sub16), .cin(cin16),
    .out_valid(out_valid16), .out_ready(out_ready16), .s(s16), .c(c16), .zero(zero16)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(ovf16)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       z;
    logic       o;
  } res_t;

  function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb, input logic msub, input logic mcin);
    res_t r;
    logic [7:0] be;
    logic [8:0] t;
    be  = msub ? ~mb : mb;
    t   = {1'b0, ma} + {1'b0, be} + {8'd0, msub ? !mcin : mcin};
    r.s = t[7:0];
    r.c = t[8];
    r.z = (t[7:0] == 8'd0);
    r.o = (ma[7] == be[7]) && (t[7] != ma[7]);
    return r;
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer
  res_t exp_q[$];
  logic prev_stall = 1'b0;
  logic prev_rst   = 1'b0;
  res_t held;

  always @(negedge clk) begin
    res_t e;
    check("in_ready_rule", in_ready, !out_valid || out_ready);
    if (prev_rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_s", s_o, 0);
      check("rst_c", c_o, 0);
      check("rst_zero", zero_o, 0);
    end
    if (prev_stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_s", s_o, held.s);
      check("stall_c", c_o, held.c);
      check("stall_zero", zero_o, held.z);
    end
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
      prev_rst   = 1'b1;
    end else begin
      prev_rst = 1'b0;
      if (out_valid && out_ready) begin
        out_xfers++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_s", s_o, e.s);
          check("sb_c", c_o, e.c);
          check("sb_zero", zero_o, e.z);
`ifdef ADDER_PIPE_OVF_EN
          check("sb_ovf", ovf_o, e.o);
`endif
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a_i, b_i, sub_i, cin_i));
      prev_stall = out_valid && !out_ready;
      held.s = s_o;
      held.c = c_o;
      held.z = zero_o;
      held.o = 1'b0;
    end
  end

  task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic ts, input logic tc);
    int  w = 0;
    logic done = 1'b0;
    a_i = ta; b_i = tb_; sub_i = ts; cin_i = tc; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      w++;
      if (!done && w >= 100) begin
        check("send_timeout", 0, 1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic one_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic ts, input logic tc,
                        input logic [7:0] es, input logic ec, input logic ez, input logic eo);
    int lat;
    send(ta, tb_, ts, tc);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_lat"}, lat, STAGES);
    check({nm, "_s"}, s_o, es);
    check({nm, "_c"}, c_o, ec);
    check({nm, "_zero"}, zero_o, ez);
`ifdef ADDER_PIPE_OVF_EN
    check({nm, "_ovf"}, ovf_o, eo);
`else
    if (eo) begin end
`endif
    @(posedge clk); #1;
  endtask

  task automatic one_op16(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic ts, input logic [15:0] es, input logic ec, input logic ez);
    int lat;
    a16 = ta; b16 = tb_; sub16 = ts; cin16 = 1'b0; in_valid16 = 1'b1;
    @(negedge clk);
    check({nm, "_in_ready"}, in_ready16, 1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_lat"}, lat, 4);
    check({nm, "_s"}, s16, es);
    check({nm, "_c"}, c16, ec);
    check({nm, "_zero"}, zero16, ez);
`ifdef ADDER_PIPE_OVF_EN
    check({nm, "_ovf"}, ovf16, 0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int w;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_i = '0; b_i = '0; sub_i = 1'b0; cin_i = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; sub16 = 1'b0; cin16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_s", s_o, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_in_ready", in_ready, 1);

    // Directed operations with hand-computed results
    one_op("add_zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    one_op("add_carry", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    one_op("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    one_op("add_cin", 8'h0F, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    one_op("sub_pos", 8'h05, 8'h03, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0);
    one_op("sub_neg", 8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    one_op("sub_bin", 8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    one_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    one_op("ovf_neg", 8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1);

    // Back-to-back stream: 10 results on consecutive cycles
    base = out_xfers;
    for (int i = 0; i < 10; i++) send(8'(i * 37 + 5), 8'(i * 53), (i % 2) == 1, (i % 4) >= 2);
    repeat (STAGES) @(posedge clk);
    #1;
    check("stream_count", out_xfers - base, 10);

    // Stream with a 3-cycle output stall in the middle
    base = out_xfers;
    fork
      begin
        for (int i = 0; i < 10; i++) send(8'(i * 29 + 200), 8'(i * 71 + 3), (i % 3) == 0, (i % 2) == 1);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        repeat (3) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    w = 0;
    while (out_xfers - base < 10 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("stall_stream_count", out_xfers - base, 10);
    check("stall_queue_empty", exp_q.size(), 0);

    // Reset with two operations in flight drops both
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b0, 1'b0);
    check("inflight_valid", out_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("drop_out_valid", out_valid, 0);
    base = out_xfers;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("drop_no_result", out_xfers - base, 0);
    check("drop_idle", out_valid, 0);

    // Wider instance: four stages
    one_op16("w16_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    one_op16("w16_sub", 16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
